mmio_timer_bank: RTL
====================

Name: mmio_timer_bank

Overview:
- Parametrised, memory-mapped bank of NUM_CH compare/match timers with a shared prescaler and a 64-bit free-running cycle counter.
- Replaces the single ad-hoc cycle counter in the FPGA top.
- Sits on the MIO bus beside the UART and display; its irq output drives the CPU timer_int input, which is currently tied low.
- All register reads are combinational; all state updates happen on the clock edge.

Parameters:
- NUM_CH, 4: number of timer channels (1..8).
- CNT_W, 32: channel counter/compare width (8..32). Bits above CNT_W read 0 and are ignored on write.
- PRE_W, 16: prescaler width.
- ADDR_W, 8: byte-offset address width. Must cover NUM_CH*16+12.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- tick_en  in  1  count enable (CPU clock-enable strobe). Gates the prescaler and the cycle counter.
- sel  in  1  chip select from MIO_BUS address decode
- we  in  1  write strobe (valid with sel)
- re  in  1  read strobe (valid with sel). Used only for the snapshot side effect.
- addr  in  ADDR_W  byte offset, word aligned (addr[1:0] ignored)
- wdata  in  32  write data
- rdata  out  32  read data, combinational
- irq_vec  out  NUM_CH  per-channel interrupt lines
- irq  out  1  OR of irq_vec

Behaviour:
- Reset (async, active-high): all registers 0, prescaler count 0, cycle counter 0, shadow 0. Outputs irq_vec=0, irq=0. With sel=0, rdata=0.
- Register map, channel c at base c*16:
  - +0 CTRL: bit0 EN, bit1 AUTO (auto-reload), bit2 IE (interrupt enable).
  - +4 CMP.
  - +8 CNT.
  - +12 STAT: bit0 MATCH, bit1 OVF. Write-1-to-clear.
- Global registers at G=NUM_CH*16:
  - G+0 PRE: divisor minus 1.
  - G+4 CYC_LO: read-only.
  - G+8 CYC_HI_SNAP: read-only.
- Unmapped offsets read 0; writes to them are ignored.
- Prescaler:
  - On a clk edge with tick_en=1: if pcnt==PRE, then pcnt<=0 and tick=1 this cycle; otherwise pcnt<=pcnt+1.
  - PRE=0 gives a tick on every enabled cycle.
  - Writing PRE also clears pcnt to 0.
- Channel on tick with EN=1:
  - If CNT==CMP: set MATCH. If AUTO=1, CNT<=0. If AUTO=0, CNT holds and EN<=0 (one-shot stop).
  - Otherwise CNT<=CNT+1, wrapping from 2^CNT_W-1 to 0 and setting OVF.
  - CMP=0 with AUTO=1 gives a MATCH on every tick.
- Priority when events coincide in one cycle:
  - CPU write to CNT/CTRL beats the tick update.
  - A hardware set of MATCH/OVF beats a write-1-clear of the same bit.
  - A write of EN=1 while a one-shot match clears EN leaves EN=1.
- irq_vec[c] = MATCH_c & IE_c. It is level and stays asserted until cleared.
- Cycle counter:
  - 64-bit, increments every clk with tick_en=1, wraps at 2^64.
  - A read of CYC_LO (sel&re at G+4) latches the upper 32 bits into the shadow on that edge, taken from the same pre-increment value returned as LO.
  - CYC_HI_SNAP returns the shadow.
- Latency:
  - Writes take effect on the next edge.
  - MATCH and irq rise on the edge of the matching tick, so irq is visible one cycle after the tick cycle begins.
- Reset asserted mid-count clears everything immediately, with no clk edge required.

Test Plan:
- Reset, then read every mapped offset -> all reads 0; irq=0.
- Prescaler: PRE=3, ch0 CMP=5, CTRL=0x7 (EN|AUTO|IE), tick_en=1 -> MATCH and irq at clk 24 (6 ticks × 4 cycles); CNT then reads 0; another MATCH after 24 further cycles.
- One-shot and clear: ch1 CMP=2, CTRL=0x5, PRE=0 -> MATCH after 3 cycles, EN reads 0, CNT holds 2. Write STAT=1 -> irq_vec[1] drops next cycle. Clear issued in the same cycle as a new match -> MATCH stays 1.
- Overflow (CNT_W=8): CNT=0xFE, CMP=0x10, EN=1, PRE=0 -> after 2 ticks CNT=0x00 and OVF=1 with MATCH=0; irq stays 0 because OVF does not drive irq.
- Write/tick collision: write CNT=0x40 on a tick cycle -> CNT reads 0x40, not the incremented value.
- Snapshot: force cycle counter to 0x0000_0001_FFFF_FFFF, read CYC_LO -> 0xFFFF_FFFF; next-cycle read of CYC_HI_SNAP -> 0x0000_0001 even though the live counter is now 0x2_0000_0000.

Source files
------------

// File: rtl/mmio_timer_bank.sv
// Memory-mapped bank of compare/match timers with a shared prescaler and a
// 64-bit free-running cycle counter that has a snapshot register for its upper half.
module mmio_timer_bank #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32,
  parameter int PRE_W  = 16,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick_en,
  input  logic              sel,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic [NUM_CH-1:0] irq_vec,
  output logic              irq
);

  localparam int WW = ADDR_W - 2;
  localparam logic [WW-1:0] W_PRE    = WW'(NUM_CH * 4);
  localparam logic [WW-1:0] W_CYC_LO = WW'(NUM_CH * 4 + 1);
  localparam logic [WW-1:0] W_CYC_HI = WW'(NUM_CH * 4 + 2);

  logic [WW-1:0]    word;
  logic             wr_any;
  logic             tick;
  logic [PRE_W-1:0] pre_reg, pcnt_reg;
  logic [63:0]      cyc_reg;
  logic [31:0]      shadow_reg;
  logic [31:0]      ch_rd [NUM_CH];
  logic             unused_ok;

  assign word      = addr[ADDR_W-1:2];
  assign wr_any    = sel & we;
  assign tick      = tick_en && (pcnt_reg == pre_reg);
  assign unused_ok = ^{addr[1:0], wdata};

  // Writing PRE restarts the division so the new period starts cleanly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_reg  <= '0;
      pcnt_reg <= '0;
    end else if (wr_any && word == W_PRE) begin
      pre_reg  <= wdata[PRE_W-1:0];
      pcnt_reg <= '0;
    end else if (tick_en) begin
      pcnt_reg <= tick ? '0 : pcnt_reg + PRE_W'(1);
    end
  end

  // Shadow captures the same pre-increment value whose low half is being read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_reg    <= '0;
      shadow_reg <= '0;
    end else begin
      if (tick_en)
        cyc_reg <= cyc_reg + 64'd1;
      if (sel && re && word == W_CYC_LO)
        shadow_reg <= cyc_reg[63:32];
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      localparam logic [WW-1:0] W_CTRL = WW'(gi * 4);
      localparam logic [WW-1:0] W_CMP  = WW'(gi * 4 + 1);
      localparam logic [WW-1:0] W_CNT  = WW'(gi * 4 + 2);
      localparam logic [WW-1:0] W_STAT = WW'(gi * 4 + 3);

      logic             en_reg, auto_reg, ie_reg, match_reg, ovf_reg;
      logic [CNT_W-1:0] cmp_reg, cnt_reg;
      logic             en_next, match_next, ovf_next;
      logic [CNT_W-1:0] cnt_next;
      logic             wr_ctrl, wr_cmp, wr_cnt, wr_stat;

      assign wr_ctrl = wr_any && word == W_CTRL;
      assign wr_cmp  = wr_any && word == W_CMP;
      assign wr_cnt  = wr_any && word == W_CNT;
      assign wr_stat = wr_any && word == W_STAT;

      // Order matters: clears first, hardware sets override them, CPU writes override ticks.
      always_comb begin
        en_next    = en_reg;
        cnt_next   = cnt_reg;
        match_next = match_reg;
        ovf_next   = ovf_reg;
        if (wr_stat) begin
          if (wdata[0]) match_next = 1'b0;
          if (wdata[1]) ovf_next   = 1'b0;
        end
        if (tick && en_reg) begin
          if (cnt_reg == cmp_reg) begin
            match_next = 1'b1;
            if (auto_reg) cnt_next = '0;
            else          en_next  = 1'b0;
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
            if (&cnt_reg) ovf_next = 1'b1;
          end
        end
        if (wr_ctrl) en_next  = wdata[0];
        if (wr_cnt)  cnt_next = wdata[CNT_W-1:0];
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          en_reg    <= 1'b0;
          auto_reg  <= 1'b0;
          ie_reg    <= 1'b0;
          match_reg <= 1'b0;
          ovf_reg   <= 1'b0;
          cmp_reg   <= '0;
          cnt_reg   <= '0;
        end else begin
          en_reg    <= en_next;
          cnt_reg   <= cnt_next;
          match_reg <= match_next;
          ovf_reg   <= ovf_next;
          if (wr_ctrl) begin
            auto_reg <= wdata[1];
            ie_reg   <= wdata[2];
          end
          if (wr_cmp)
            cmp_reg <= wdata[CNT_W-1:0];
        end
      end

      assign irq_vec[gi] = match_reg & ie_reg;
      assign ch_rd[gi]   = (word == W_CTRL) ? {29'd0, ie_reg, auto_reg, en_reg} :
                           (word == W_CMP)  ? 32'(cmp_reg) :
                           (word == W_CNT)  ? 32'(cnt_reg) :
                           (word == W_STAT) ? {30'd0, ovf_reg, match_reg} : 32'd0;
    end
  endgenerate

  assign irq = |irq_vec;

  always_comb begin
    rdata = 32'd0;
    if (sel) begin
      for (int i = 0; i < NUM_CH; i++)
        rdata = rdata | ch_rd[i];
      if (word == W_PRE)    rdata = 32'(pre_reg);
      if (word == W_CYC_LO) rdata = cyc_reg[31:0];
      if (word == W_CYC_HI) rdata = shadow_reg;
    end
  end

endmodule
